pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Parametrised program-counter generator for the RV32I fetch stage.
//  Holds the PC and selects the next PC by priority: trap, resolved redirect,
//  return-address-stack (RAS) prediction, then sequential.
//  Adds stall, misaligned-target detection and a circular RAS for call/return.
//  Sits between control/branch-resolution logic and instruction memory.
// PARAMETERS
//  XLEN       32             PC / address width
//  RESET_PC   32'h0100_0000  PC after reset (start of instruction memory)
//  INST_BYTES 4              sequential increment; power of two; sets alignment
//  RAS_DEPTH  4              return-address-stack entries; >=2
// PORTS
//  clk             in   1                    clock, rising edge
//  reset           in   1                    asynchronous reset, active-low
//  enable          in   1                    1 = PC may advance; 0 = stall
//  trap_valid      in   1                    take trap this cycle
//  trap_target     in   XLEN                 trap vector address
//  redirect_valid  in   1                    resolved branch/jump taken
//  redirect_target in   XLEN                 resolved target address
//  call_push       in   1                    instruction at current_pc is a call
//  ret_pop         in   1                    instruction at current_pc is a return
//  current_pc      out  XLEN                 registered PC
//  pc_plus_inc     out  XLEN                 current_pc + INST_BYTES (comb)
//  ras_top         out  XLEN                 top RAS entry (0 when empty)
//  ras_count       out  $clog2(RAS_DEPTH+1)  valid RAS entries
//  misaligned      out  1                    registered 1-cycle error pulse
//  bad_addr        out  XLEN                 last rejected redirect target
// BEHAVIOUR
//  Reset (async, reset==0): current_pc=RESET_PC; ras_count=0; RAS pointer=0;
//   all RAS entries=0; misaligned=0; bad_addr=0. Active on next edge after release.
//  Next-PC priority, evaluated each rising edge:
//   1 trap_valid: PC<=trap_target. Ignores enable. RAS count cleared to 0.
//   2 enable & redirect_valid & aligned target: PC<=redirect_target.
//   3 enable & redirect_valid & misaligned target (low log2(INST_BYTES) bits!=0):
//     PC holds; misaligned<=1 next cycle; bad_addr<=redirect_target.
//   4 enable & ret_pop & ras_count!=0: PC<=ras_top; RAS popped.
//   5 enable: PC<=pc_plus_inc. ret_pop on empty RAS falls through here.
//   6 otherwise (stall): PC and RAS hold.
//  misaligned: high exactly one cycle per rejected redirect; 0 otherwise.
//  Arithmetic: pc_plus_inc wraps modulo 2^XLEN (32'hFFFF_FFFC+4 -> 0).
//  RAS is a circular buffer with a write pointer:
//   push (call_push & enable & !trap_valid, even with redirect) writes pc_plus_inc.
//   Push when full overwrites the oldest entry; ras_count saturates at RAS_DEPTH.
//   Pop acts only in priority case 4; pop on empty is a no-op.
//   Push and pop in the same cycle: next PC=old top; top replaced by pc_plus_inc;
//   ras_count unchanged.
//   Trap clears ras_count and pointer; entry contents need not be cleared.
//  Latency: current_pc updates one cycle after the qualifying inputs; no bubbles.
// STRUCTURE
//  Package pc_pkg holds:
//   - XLEN_DEF and RESET_PC_DEF.
//   - typedef enum logic [1:0] {NPC_SEQ, NPC_RET, NPC_REDIR, NPC_TRAP} npc_sel_e.
//  pc_gen holds: priority mux, PC register, misaligned/bad_addr registers.
//  One sub-module, ras_stack (XLEN, RAS_DEPTH):
//   - inputs: push, pop, push_data, clear.
//   - outputs: top, count.
// TESTING
//  1 Reset: hold reset=0, enable=1 -> current_pc=32'h0100_0000, ras_count=0;
//    after release, 3 enabled cycles -> 0x0100_0004, 0x0100_0008, 0x0100_000C.
//  2 Stall/trap: enable=0 for 2 cycles -> PC holds; trap_valid=1,
//    trap_target=0x0100_0100 with enable=0 -> PC=0x0100_0100 next cycle.
//  3 Priority: trap(0x200) + redirect(0x300) + ret_pop same cycle -> PC=0x200,
//    ras_count=0.
//  4 Misaligned: redirect_target=0x0100_0042 at PC 0x0100_0010 -> PC holds
//    0x0100_0010; misaligned=1 for one cycle; bad_addr=0x0100_0042.
//  5 RAS: push at PCs 0x10, 0x20, 0x30, 0x40, 0x50 (DEPTH=4) -> count=4;
//    then 4 pops return 0x54, 0x44, 0x34, 0x24; 5th pop -> sequential, count=0.
//  6 Push+pop same cycle at PC 0x80 with top 0x24 -> PC=0x24, top=0x84,
//    count unchanged; PC 0xFFFF_FFFC sequential -> 0x0000_0000.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared defaults and next-PC source encoding for the fetch-stage PC generator.
package pc_pkg;
    localparam int XLEN_DEF = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0100_0000;
    typedef enum logic [1:0] {NPC_SEQ, NPC_RET, NPC_REDIR, NPC_TRAP} npc_sel_e;
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           clear,
    input  logic [XLEN-1:0]                push_data,
    output logic [XLEN-1:0]                top,
    output logic [$clog2(RAS_DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH+1);
    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0] wptr, tptr, nptr;
    logic do_pop;
    always_comb begin
        tptr   = wptr == '0 ? PW'(RAS_DEPTH-1) : wptr - PW'(1);
        nptr   = wptr == PW'(RAS_DEPTH-1) ? '0 : wptr + PW'(1);
        do_pop = pop && count != '0;
        top    = count != '0 ? mem[tptr] : '0;
    end
    // Push+pop replaces the top in place, so pointer and count stay put.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            count <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            wptr  <= '0;
            count <= '0;
        end else if (push && do_pop) begin
            mem[tptr] <= push_data;
        end else if (push) begin
            mem[wptr] <= push_data;
            wptr      <= nptr;
            count     <= count == CW'(RAS_DEPTH) ? count : count + CW'(1);
        end else if (do_pop) begin
            wptr  <= tptr;
            count <= count - CW'(1);
        end
    end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: RV32I fetch PC register with trap/redirect/RAS/sequential next-PC priority.
module pc_gen
    import pc_pkg::*;
#(
    parameter int               XLEN       = XLEN_DEF,
    parameter logic [XLEN-1:0]  RESET_PC   = RESET_PC_DEF,
    parameter int               INST_BYTES = 4,
    parameter int               RAS_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           trap_valid,
    input  logic [XLEN-1:0]                trap_target,
    input  logic                           redirect_valid,
    input  logic [XLEN-1:0]                redirect_target,
    input  logic                           call_push,
    input  logic                           ret_pop,
    output logic [XLEN-1:0]                current_pc,
    output logic [XLEN-1:0]                pc_plus_inc,
    output logic [XLEN-1:0]                ras_top,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           misaligned,
    output logic [XLEN-1:0]                bad_addr
);
    npc_sel_e sel;
    logic mis, rej, load, push, pop;
    logic [XLEN-1:0] next_pc;
    always_comb begin
        pc_plus_inc = current_pc + XLEN'(INST_BYTES);
        mis  = |(redirect_target & XLEN'(INST_BYTES-1));
        sel  = trap_valid ? NPC_TRAP :
               redirect_valid ? NPC_REDIR :
               (ret_pop && ras_count != '0) ? NPC_RET : NPC_SEQ;
        rej  = !trap_valid && enable && redirect_valid && mis;
        load = trap_valid || (enable && !rej);
        push = call_push && enable && !trap_valid;
        pop  = enable && sel == NPC_RET;
        next_pc = sel == NPC_TRAP  ? trap_target :
                  sel == NPC_REDIR ? redirect_target :
                  sel == NPC_RET   ? ras_top : pc_plus_inc;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            current_pc <= RESET_PC;
            misaligned <= 1'b0;
            bad_addr   <= '0;
        end else begin
            if (load) current_pc <= next_pc;
            misaligned <= rej;
            if (rej) bad_addr <= redirect_target;
        end
    end
    ras_stack #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .clear     (trap_valid),
        .push_data (pc_plus_inc),
        .top       (ras_top),
        .count     (ras_count)
    );
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed-vector bench for pc_gen with hand-computed expectations.
module tb_pc_gen;
    logic        clk = 1'b0;
    logic        reset, enable, trap_valid, redirect_valid, call_push, ret_pop;
    logic [31:0] trap_target, redirect_target;
    logic [31:0] current_pc, pc_plus_inc, ras_top, bad_addr;
    logic [2:0]  ras_count;
    logic        misaligned;
    int vecs = 0;
    int errs = 0;

    pc_gen dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .trap_valid      (trap_valid),
        .trap_target     (trap_target),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .call_push       (call_push),
        .ret_pop         (ret_pop),
        .current_pc      (current_pc),
        .pc_plus_inc     (pc_plus_inc),
        .ras_top         (ras_top),
        .ras_count       (ras_count),
        .misaligned      (misaligned),
        .bad_addr        (bad_addr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic redir(input logic [31:0] t);
        redirect_valid  = 1'b1;
        redirect_target = t;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; trap_valid = 1'b0; redirect_valid = 1'b0;
        call_push = 1'b0; ret_pop = 1'b0; trap_target = '0; redirect_target = '0;
        // 1: reset and sequential fetch
        step(); step();
        chk("rst_pc", current_pc, 32'h0100_0000);
        chk("rst_cnt", 32'(ras_count), 0);
        chk("rst_top", ras_top, 0);
        chk("rst_mis", 32'(misaligned), 0);
        chk("rst_bad", bad_addr, 0);
        reset = 1'b1;
        step(); chk("seq1", current_pc, 32'h0100_0004);
        step(); chk("seq2", current_pc, 32'h0100_0008);
        step(); chk("seq3", current_pc, 32'h0100_000C);
        chk("plus_inc", pc_plus_inc, 32'h0100_0010);
        // 2: stall then trap while stalled
        enable = 1'b0; call_push = 1'b1;
        step(); step();
        chk("stall_pc", current_pc, 32'h0100_000C);
        chk("stall_nopush", 32'(ras_count), 0);
        call_push = 1'b0; trap_valid = 1'b1; trap_target = 32'h0100_0100;
        step(); chk("trap_pc", current_pc, 32'h0100_0100);
        trap_valid = 1'b0; enable = 1'b1; call_push = 1'b1;
        step();
        chk("push_pc", current_pc, 32'h0100_0104);
        chk("push_cnt", 32'(ras_count), 1);
        chk("push_top", ras_top, 32'h0100_0104);
        // 3: trap beats redirect and ret_pop, clears RAS
        call_push = 1'b0; trap_valid = 1'b1; trap_target = 32'h200; redir(32'h300); ret_pop = 1'b1;
        step();
        chk("prio_pc", current_pc, 32'h200);
        chk("prio_cnt", 32'(ras_count), 0);
        trap_valid = 1'b0; ret_pop = 1'b0;
        // 4: misaligned redirect rejected
        redir(32'h0100_0010); step();
        chk("redir_pc", current_pc, 32'h0100_0010);
        redir(32'h0100_0042); step();
        chk("mis_pc", current_pc, 32'h0100_0010);
        chk("mis_pulse", 32'(misaligned), 1);
        chk("mis_bad", bad_addr, 32'h0100_0042);
        redirect_valid = 1'b0; enable = 1'b0; step();
        chk("mis_clr", 32'(misaligned), 0);
        chk("mis_hold", current_pc, 32'h0100_0010);
        chk("bad_hold", bad_addr, 32'h0100_0042);
        enable = 1'b1;
        // 5: five calls saturate a depth-4 RAS, then unwind
        redir(32'h10); step();
        call_push = 1'b1;
        redir(32'h20); step();
        redir(32'h30); step();
        redir(32'h40); step();
        redir(32'h50); step();
        chk("ras_pc50", current_pc, 32'h50);
        redir(32'h1000); step();
        chk("ras_full", 32'(ras_count), 4);
        chk("ras_top54", ras_top, 32'h54);
        call_push = 1'b0; redirect_valid = 1'b0; ret_pop = 1'b1;
        step(); chk("pop1", current_pc, 32'h54); chk("pop1_cnt", 32'(ras_count), 3);
        step(); chk("pop2", current_pc, 32'h44);
        step(); chk("pop3", current_pc, 32'h34);
        step(); chk("pop4", current_pc, 32'h24); chk("pop4_cnt", 32'(ras_count), 0);
        chk("empty_top", ras_top, 0);
        step(); chk("pop_empty", current_pc, 32'h28);
        chk("pop_empty_cnt", 32'(ras_count), 0);
        // 6: simultaneous push and pop, then address wrap
        ret_pop = 1'b0; redir(32'h20); step();
        call_push = 1'b1; redir(32'h80); step();
        chk("pp_setup_top", ras_top, 32'h24);
        redirect_valid = 1'b0; ret_pop = 1'b1; step();
        chk("pp_pc", current_pc, 32'h24);
        chk("pp_top", ras_top, 32'h84);
        chk("pp_cnt", 32'(ras_count), 1);
        call_push = 1'b0; ret_pop = 1'b0; redir(32'hFFFF_FFFC); step();
        chk("wrap_inc", pc_plus_inc, 32'h0);
        redirect_valid = 1'b0; step();
        chk("wrap_pc", current_pc, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
